// File: rtl/board_input_conditioner.sv
// board_input_conditioner
// Synchronizes and debounces the DE2-115 slide switches and pushbuttons.
// It also derives key-press toggles and a 6-bit press counter, and packs
// everything into one registered 32-bit status word for a read-only PIO.
// Word layout: [17:0] switches, [21:18] keys pressed, [25:22] press toggles,
// [31:26] press count.
module board_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [17:0] sw,
  input  logic [3:0]  key,
  output logic [31:0] inport_word
);

  localparam int          NBITS    = 22;
  localparam logic [19:0] CNT_MAX  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic        KEY_REL  = (KEY_ACTIVE_LOW != 0);
  // The synchronizer idles at the electrical "released" level so that a
  // reset never looks like a key press.
  localparam logic [21:0] SYNC_RST = {{4{KEY_REL}}, 18'b0};

  // Number of press events in one cycle (0..4).
  function automatic logic [2:0] count4(input logic [3:0] v);
    count4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [21:0] sync1_q, sync2_q;
  logic [21:0] lvl;
  logic [21:0] stab_q, stab_d;
  logic [19:0] cnt_q [NBITS];
  logic [19:0] cnt_d [NBITS];
  logic [3:0]  press;
  logic [3:0]  tog_q, tog_d;
  logic [5:0]  pcnt_q, pcnt_d;
  logic [31:0] word_q, word_d;

  // Two-flop synchronizer on every raw input bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {key, sw};
      sync2_q <= sync1_q;
    end
  end

  // Keys are converted to an active-high "pressed" level before debouncing.
  assign lvl = {(KEY_REL ? ~sync2_q[21:18] : sync2_q[21:18]), sync2_q[17:0]};

  // Per-bit debounce: a new level is accepted only after it has differed
  // from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      if (lvl[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stab_d[i] = lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // Press events are taken from the accepted level's next state. Toggles
  // and the counter then move on the same edge as the accepted key level.
  always_comb begin
    press  = stab_d[21:18] & ~stab_q[21:18];
    tog_d  = tog_q ^ press;
    pcnt_d = pcnt_q + {3'b000, count4(press)};
    word_d = {pcnt_q, tog_q, stab_q[21:18], stab_q[17:0]};
  end

  // Debounce, event and output state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stab_q <= '0;
      for (int i = 0; i < NBITS; i++) begin
        cnt_q[i] <= '0;
      end
      tog_q  <= '0;
      pcnt_q <= '0;
      word_q <= '0;
    end else begin
      stab_q <= stab_d;
      for (int i = 0; i < NBITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tog_q  <= tog_d;
      pcnt_q <= pcnt_d;
      word_q <= word_d;
    end
  end

  assign inport_word = word_q;

endmodule
